// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: feeds buffered sensor samples to the FIR MAC core one at a time,
// arbitrates core access between sample processing, coefficient writes and clear, holds
// each result in a one-entry valid/ready buffer and watchdogs every computation.
module fir_sample_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          smp_valid_i,
  input  logic [DATA_WIDTH-1:0]         smp_data_i,
  output logic                          smp_ready_o,
  input  logic                          coef_wr_i,
  input  logic [ADDR_WIDTH-1:0]         coef_addr_i,
  input  logic [DATA_WIDTH-1:0]         coef_data_i,
  output logic                          coef_ack_o,
  input  logic                          clr_req_i,
  output logic                          res_valid_o,
  output logic [DATA_WIDTH-1:0]         res_data_o,
  input  logic                          res_ready_i,
  output logic                          core_clr_o,
  output logic                          core_en_o,
  output logic                          core_coef_we_o,
  output logic [ADDR_WIDTH-1:0]         core_coef_addr_o,
  output logic [DATA_WIDTH-1:0]         core_coef_data_o,
  output logic [DATA_WIDTH-1:0]         core_sample_o,
  input  logic [DATA_WIDTH-1:0]         core_result_i,
  input  logic                          core_result_valid_i,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COEF, S_ISSUE, S_WAIT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [WW-1:0]         wd_cnt;
  logic                  fifo_empty, fifo_full, push, flush, start_issue;

  assign fifo_empty  = (fifo_level_o == '0);
  assign fifo_full   = (fifo_level_o == LW'(FIFO_DEPTH));
  assign smp_ready_o = !fifo_full;
  // CLEAR drops the whole FIFO, including anything offered in that same cycle.
  assign flush       = (state == S_CLEAR);
  assign push        = smp_valid_i && !fifo_full && !flush;
  // Clear and coefficient writes win over samples; a full result buffer stalls issue.
  assign start_issue = (state == S_IDLE) && !clr_req_i && !coef_wr_i && !fifo_empty && !res_valid_o;
  assign busy_o      = (state != S_IDLE) || !fifo_empty;

  // Sample storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= smp_data_i;
  end

  // FIFO pointers and occupancy; pointers wrap naturally as the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level_o <= '0;
    end else if (flush) begin
      rd_ptr       <= wr_ptr;
      fifo_level_o <= '0;
    end else begin
      if (push)        wr_ptr <= wr_ptr + 1'b1;
      if (start_issue) rd_ptr <= rd_ptr + 1'b1;
      fifo_level_o <= fifo_level_o + LW'(push) - LW'(start_issue);
    end
  end

  // Sequencing FSM with registered core strobes, result buffer and watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= S_IDLE;
      core_clr_o       <= 1'b0;
      core_en_o        <= 1'b0;
      core_coef_we_o   <= 1'b0;
      coef_ack_o       <= 1'b0;
      core_coef_addr_o <= '0;
      core_coef_data_o <= '0;
      core_sample_o    <= '0;
      res_valid_o      <= 1'b0;
      res_data_o       <= '0;
      timeout_o        <= 1'b0;
      wd_cnt           <= '0;
    end else begin
      core_clr_o     <= 1'b0;
      core_en_o      <= 1'b0;
      core_coef_we_o <= 1'b0;
      coef_ack_o     <= 1'b0;
      if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clr_req_i) begin
            state      <= S_CLEAR;
            core_clr_o <= 1'b1;
            timeout_o  <= 1'b0;
          end else if (coef_wr_i) begin
            state            <= S_COEF;
            core_coef_we_o   <= 1'b1;
            coef_ack_o       <= 1'b1;
            core_coef_addr_o <= coef_addr_i;
            core_coef_data_o <= coef_data_i;
          end else if (start_issue) begin
            state         <= S_ISSUE;
            core_en_o     <= 1'b1;
            core_sample_o <= mem[rd_ptr];
            wd_cnt        <= '0;
          end
        end
        S_CLEAR: begin
          res_valid_o <= 1'b0;
          state       <= S_IDLE;
        end
        S_COEF:  state <= S_IDLE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (core_result_valid_i) begin
            res_data_o  <= core_result_i;
            res_valid_o <= 1'b1;
            state       <= S_IDLE;
          end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
            // Core never answered: drop the sample and reset the core; entering
            // CLEAR this way leaves the sticky flag set.
            timeout_o  <= 1'b1;
            core_clr_o <= 1'b1;
            state      <= S_CLEAR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: directed tables and corner sequences plus a randomized
// phase, all checked by a queue-based scoreboard (sample order, result order, occupancy).
module tb_fir_sample_sequencer;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic smp_valid_i, smp_ready_o, coef_wr_i, coef_ack_o, clr_req_i;
  logic [DW-1:0] smp_data_i, coef_data_i, res_data_o, core_coef_data_o, core_sample_o, core_result_i;
  logic [AW-1:0] coef_addr_i, core_coef_addr_o;
  logic res_valid_o, res_ready_i, core_clr_o, core_en_o, core_coef_we_o, core_result_valid_i;
  logic busy_o, timeout_o;
  logic [2:0] fifo_level_o;

  always #5 clk = ~clk;

  fir_sample_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .smp_valid_i(smp_valid_i), .smp_data_i(smp_data_i), .smp_ready_o(smp_ready_o),
    .coef_wr_i(coef_wr_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i), .coef_ack_o(coef_ack_o),
    .clr_req_i(clr_req_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i),
    .core_clr_o(core_clr_o), .core_en_o(core_en_o), .core_coef_we_o(core_coef_we_o),
    .core_coef_addr_o(core_coef_addr_o), .core_coef_data_o(core_coef_data_o),
    .core_sample_o(core_sample_o), .core_result_i(core_result_i),
    .core_result_valid_i(core_result_valid_i), .busy_o(busy_o), .timeout_o(timeout_o),
    .fifo_level_o(fifo_level_o));

  int checks = 0;
  int fails = 0;
  logic [DW-1:0] sample_q[$];
  logic [DW-1:0] exp_res_q[$];
  logic [DW-1:0] core_res_q[$];
  int n_issue = 0, n_res = 0, n_we = 0, n_ack = 0;
  bit resp_en = 1'b1, stray_en = 1'b0, rand_delay = 1'b0;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [AW-1:0] exp_addr; logic [DW-1:0] exp_data; } coef_vec_t;
  typedef struct { logic [DW-1:0] smp; logic [DW-1:0] core_res; logic [DW-1:0] exp_res; } smp_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s (event missing or unexpected) @%0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Core model: answers each core_en_o after a (possibly random) delay, optionally
  // throwing stray result pulses while no computation is outstanding.
  initial begin
    int cnt;
    bit pend;
    logic [DW-1:0] v;
    cnt = 0; pend = 0;
    core_result_valid_i = 1'b0;
    core_result_i = '0;
    forever begin
      @(negedge clk);
      core_result_valid_i = 1'b0;
      if (!rst_ni) pend = 0;
      else begin
        if (pend) begin
          if (cnt == 0) begin
            if (core_res_q.size() > 0) v = core_res_q.pop_front();
            else begin v = DW'($urandom); exp_res_q.push_back(v); end
            core_result_i = v;
            core_result_valid_i = 1'b1;
            pend = 0;
          end else cnt--;
        end else if (resp_en && stray_en && !core_en_o && $urandom_range(0, 7) == 0) begin
          core_result_i = 16'hDEAD;
          core_result_valid_i = 1'b1;
        end
        if (core_en_o && resp_en) begin
          pend = 1;
          cnt = rand_delay ? int'($urandom_range(0, 4)) : 0;
        end
      end
    end
  end

  // Scoreboard: FIFO is a queue of accepted samples; results come out in core order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        sample_q.delete();
        exp_res_q.delete();
      end else begin
        if (core_en_o) begin
          n_issue++;
          chk("issue_resbuf_empty", 32'(res_valid_o), 0);
          if (sample_q.size() == 0) fail_now("issue_without_sample");
          else chk("issue_order", 32'(core_sample_o), 32'(sample_q.pop_front()));
        end
        if (res_valid_o && res_ready_i) begin
          n_res++;
          if (exp_res_q.size() == 0) fail_now("result_unexpected");
          else chk("result_order", 32'(res_data_o), 32'(exp_res_q.pop_front()));
        end
        if (core_coef_we_o) begin
          n_we++;
          chk("coef_ack_with_we", 32'(coef_ack_o), 1);
        end
        if (coef_ack_o) n_ack++;
        chk("fifo_level", 32'(fifo_level_o), 32'(sample_q.size()));
        chk("smp_ready", 32'(smp_ready_o), 32'(sample_q.size() < DEPTH));
        if (sample_q.size() != 0) chk("busy_when_queued", 32'(busy_o), 1);
        if (core_clr_o) begin
          sample_q.delete();
          exp_res_q.delete();
        end else if (smp_valid_i && smp_ready_o) sample_q.push_back(smp_data_i);
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_core_en"}, 32'(core_en_o), 0);
    chk({tag, "_core_clr"}, 32'(core_clr_o), 0);
    chk({tag, "_coef_we"}, 32'(core_coef_we_o), 0);
    chk({tag, "_coef_ack"}, 32'(coef_ack_o), 0);
    chk({tag, "_res_valid"}, 32'(res_valid_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_level"}, 32'(fifo_level_o), 0);
    chk({tag, "_sample"}, 32'(core_sample_o), 0);
    chk({tag, "_res_data"}, 32'(res_data_o), 0);
    // Ready only means "FIFO not full", so an empty FIFO accepts.
    chk({tag, "_smp_ready"}, 32'(smp_ready_o), 1);
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    smp_valid_i = 1'b1;
    smp_data_i = d;
    tick();
    smp_valid_i = 1'b0;
  endtask

  task automatic wait_en(input string nm);
    int k;
    k = 0;
    while (!core_en_o && k < 20) begin tick(); k++; end
    if (!core_en_o) fail_now(nm);
  endtask

  task automatic wait_results(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (n_res < target && k < budget) begin tick(); k++; end
    if (n_res < target) fail_now(nm);
  endtask

  initial begin
    coef_vec_t cv[4];
    smp_vec_t sv[4];
    int n0, a0, i0, cnt;
    bit ok, prev_to, coef_active;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;

    cv[0] = '{3'd3, 16'h0102, 3'd3, 16'h0102};
    cv[1] = '{3'd0, 16'hFFFF, 3'd0, 16'hFFFF};
    cv[2] = '{3'd7, 16'h8000, 3'd7, 16'h8000};
    cv[3] = '{3'd5, 16'h1234, 3'd5, 16'h1234};
    sv[0] = '{16'h0010, 16'h00AA, 16'h00AA};
    sv[1] = '{16'h0020, 16'h00BB, 16'h00BB};
    sv[2] = '{16'h7FFF, 16'h0001, 16'h0001};
    sv[3] = '{16'h8000, 16'hFFFF, 16'hFFFF};

    smp_valid_i = 0; smp_data_i = '0; coef_wr_i = 0; coef_addr_i = '0; coef_data_i = '0;
    clr_req_i = 0; res_ready_i = 0;

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #2 check_quiet("rst_held");
    rst_ni = 1'b1;
    tick();
    check_quiet("rst_rel");

    // Latency: accepted at edge t -> ISSUE in cycle t+1, result the cycle after the core pulse.
    res_ready_i = 1'b1;
    core_res_q.push_back(16'h1111);
    exp_res_q.push_back(16'h1111);
    smp_valid_i = 1'b1; smp_data_i = 16'h0055;
    tick();
    smp_valid_i = 1'b0;
    chk("lat_no_en_at_t", 32'(core_en_o), 0);
    tick();
    chk("lat_en_at_t1", 32'(core_en_o), 1);
    chk("lat_sample", 32'(core_sample_o), 32'h55);
    tick();
    chk("lat_res_not_yet", 32'(res_valid_o), 0);
    tick();
    chk("lat_res_valid", 32'(res_valid_o), 1);
    chk("lat_res_data", 32'(res_data_o), 32'h1111);
    repeat (2) tick();

    // Coefficient write table: each held request gives exactly one strobe and ack.
    for (int i = 0; i < 4; i++) begin
      n0 = n_we; a0 = n_ack;
      coef_wr_i = 1'b1; coef_addr_i = cv[i].addr; coef_data_i = cv[i].data;
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
        tick();
        if (coef_ack_o) ok = 1;
      end
      if (!ok) fail_now("coef_no_ack");
      else begin
        chk("coef_we", 32'(core_coef_we_o), 1);
        chk("coef_addr", 32'(core_coef_addr_o), 32'(cv[i].exp_addr));
        chk("coef_data", 32'(core_coef_data_o), 32'(cv[i].exp_data));
      end
      coef_wr_i = 1'b0;
      repeat (3) tick();
      chk("coef_we_count", n_we - n0, 1);
      chk("coef_ack_count", n_ack - a0, 1);
    end

    // Sample/result table, pushed back-to-back; results must appear in order.
    n0 = n_res;
    for (int i = 0; i < 4; i++) begin
      core_res_q.push_back(sv[i].core_res);
      exp_res_q.push_back(sv[i].exp_res);
      smp_valid_i = 1'b1; smp_data_i = sv[i].smp;
      tick();
    end
    smp_valid_i = 1'b0;
    wait_results(n0 + 4, 100, "table_results");
    repeat (2) tick();

    // Backpressure: five samples with the consumer stalled -> full at level 4, one ISSUE.
    res_ready_i = 1'b0;
    i0 = n_issue; n0 = n_res;
    for (int i = 0; i < 5; i++) begin
      smp_valid_i = 1'b1; smp_data_i = DW'(16'h0100 + i);
      tick();
    end
    chk("bp_level_full", 32'(fifo_level_o), 4);
    chk("bp_ready_low", 32'(smp_ready_o), 0);
    smp_data_i = 16'h01FF;
    repeat (3) tick();
    smp_valid_i = 1'b0;
    chk("bp_level_hold", 32'(fifo_level_o), 4);
    chk("bp_one_issue", n_issue - i0, 1);
    res_ready_i = 1'b1;
    wait_results(n0 + 5, 200, "bp_drain");
    repeat (2) tick();
    chk("bp_busy_done", 32'(busy_o), 0);

    // Watchdog: no core answer -> timeout after 64 WAIT cycles, then recovery.
    resp_en = 1'b0;
    push_one(16'h0077);
    wait_en("to_issue");
    cnt = 0; prev_to = 1'b0;
    while (!core_clr_o && cnt < 100) begin
      prev_to = timeout_o;
      tick();
      cnt++;
    end
    chk("to_cycles", cnt, 65);
    chk("to_flag_before", 32'(prev_to), 0);
    chk("to_flag_set", 32'(timeout_o), 1);
    tick();
    chk("to_sticky_after_clear", 32'(timeout_o), 1);
    resp_en = 1'b1;
    n0 = n_res;
    push_one(16'h0088);
    wait_results(n0 + 1, 50, "to_next_sample");
    chk("to_still_sticky", 32'(timeout_o), 1);
    clr_req_i = 1'b1;
    tick();
    chk("clr_pulse", 32'(core_clr_o), 1);
    clr_req_i = 1'b0;
    tick();
    chk("clr_resets_timeout", 32'(timeout_o), 0);

    // clr_req and coef_wr together with 2 samples queued: CLEAR first, then COEF.
    res_ready_i = 1'b0;
    push_one(16'h0099);
    cnt = 0;
    while (!res_valid_o && cnt < 20) begin tick(); cnt++; end
    if (!res_valid_o) fail_now("cc_prefill");
    push_one(16'h00A1);
    push_one(16'h00A2);
    chk("cc_level_two", 32'(fifo_level_o), 2);
    clr_req_i = 1'b1; coef_wr_i = 1'b1; coef_addr_i = 3'd6; coef_data_i = 16'hBEEF;
    tick();
    chk("cc_clear_first", 32'(core_clr_o), 1);
    chk("cc_no_coef_yet", 32'(core_coef_we_o), 0);
    clr_req_i = 1'b0;
    tick();
    chk("cc_fifo_flushed", 32'(fifo_level_o), 0);
    chk("cc_res_flushed", 32'(res_valid_o), 0);
    tick();
    chk("cc_coef_we", 32'(core_coef_we_o), 1);
    chk("cc_coef_addr", 32'(core_coef_addr_o), 6);
    chk("cc_coef_data", 32'(core_coef_data_o), 32'hBEEF);
    coef_wr_i = 1'b0;
    res_ready_i = 1'b1;
    repeat (2) tick();

    // Reset in the middle of WAIT aborts everything.
    resp_en = 1'b0;
    push_one(16'h0066);
    wait_en("rw_issue");
    repeat (3) tick();
    rst_ni = 1'b0;
    #1;
    check_quiet("rst_wait");
    tick();
    rst_ni = 1'b1;
    resp_en = 1'b1;
    i0 = n_issue;
    repeat (5) tick();
    chk("rw_no_issue", n_issue - i0, 0);
    n0 = n_res;
    push_one(16'h0067);
    wait_results(n0 + 1, 50, "rw_new_sample");

    // Randomized traffic with random core latency, stray pulses and coefficient writes.
    stray_en = 1'b1; rand_delay = 1'b1;
    coef_active = 1'b0; c_addr = '0; c_data = '0;
    for (int c = 0; c < 800; c++) begin
      if (coef_active && coef_ack_o) begin
        chk("rnd_coef_addr", 32'(core_coef_addr_o), 32'(c_addr));
        chk("rnd_coef_data", 32'(core_coef_data_o), 32'(c_data));
        coef_active = 1'b0;
        coef_wr_i = 1'b0;
      end else if (!coef_active && $urandom_range(0, 15) == 0) begin
        coef_active = 1'b1;
        c_addr = AW'($urandom); c_data = DW'($urandom);
        coef_wr_i = 1'b1; coef_addr_i = c_addr; coef_data_i = c_data;
      end
      smp_valid_i = 1'($urandom);
      smp_data_i = DW'($urandom);
      res_ready_i = 1'($urandom);
      tick();
    end
    smp_valid_i = 1'b0;
    stray_en = 1'b0;
    res_ready_i = 1'b1;
    cnt = 0;
    while ((coef_active || sample_q.size() != 0 || exp_res_q.size() != 0 || busy_o || res_valid_o) && cnt < 400) begin
      if (coef_active && coef_ack_o) begin coef_active = 1'b0; coef_wr_i = 1'b0; end
      tick();
      cnt++;
    end
    chk("rnd_drained_busy", 32'(busy_o), 0);
    chk("rnd_drained_level", 32'(fifo_level_o), 0);
    chk("rnd_drained_res", 32'(res_valid_o), 0);
    chk("rnd_no_timeout", 32'(timeout_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "time limit");
  end

endmodule
